gain_channel_scheduler: RTL and testbench

Time-shares one constant-gain multiply stage among NCH sample requesters in the control-system coprocessor. Each channel owns its own gain register, loaded over a common parameter port. Pending samples are picked round-robin, multiplied by that channel's gain, and emitted with a channel tag on a single output stream. Parameter writes take priority over sample issue, matching the existing gain-stage convention.

---
 rtl/gain_sched_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/gain_channel_scheduler.sv | 80 ++++++++
 tb/tb_gain_channel_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gain_sched_pkg.sv
// rtl/gain_sched_pkg.sv - shared constants and stage-1 slot type for the gain channel scheduler
package gain_sched_pkg;

  localparam int MSB_DEF  = 31;
  localparam int NCH_DEF  = 4;
  localparam int CW_DEF   = $clog2(NCH_DEF);
  localparam int PIPE_LAT = 2;

  // One issued sample waiting for the multiply stage
  typedef struct packed {
    logic              valid;
    logic [CW_DEF-1:0] ch;
    logic [MSB_DEF:0]  gain;
    logic [MSB_DEF:0]  data;
  } s1_slot_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant selection with a last-granted pointer
module rr_arbiter #(
  parameter int NCH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         req,
  input  logic                   advance,
  output logic [NCH-1:0]         grant,
  output logic [$clog2(NCH)-1:0] grant_idx
);

  localparam int CW = $clog2(NCH);

  logic [CW-1:0] rr_ptr_q;
  logic [CW-1:0] rr_ptr_d;
  logic [CW-1:0] cand;
  logic          found;

  // Search upward from the slot after the last winner; index wraps by truncation
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    if (rst && advance) begin
      for (int i = 1; i <= NCH; i++) begin
        cand = rr_ptr_q + CW'(i);
        if (!found && req[cand]) begin
          found     = 1'b1;
          grant_idx = cand;
        end
      end
      if (found) grant[grant_idx] = 1'b1;
    end
    rr_ptr_d = found ? grant_idx : rr_ptr_q;
  end

  // Pointer starts at the top channel so channel 0 wins first
  always_ff @(posedge clk) begin
    if (!rst) rr_ptr_q <= CW'(NCH - 1);
    else      rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/gain_channel_scheduler.sv
// rtl/gain_channel_scheduler.sv - per-channel gain registers sharing one multiply stage
module gain_channel_scheduler
  import gain_sched_pkg::*;
#(
  parameter int MSB = MSB_DEF,
  parameter int NCH = NCH_DEF,
  parameter int CW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 param_en,
  input  logic [CW-1:0]        param_ch,
  input  logic [MSB:0]         param_in,
  input  logic [NCH-1:0]       req,
  input  logic [NCH*(MSB+1)-1:0] data_in,
  output logic [NCH-1:0]       grant,
  output logic [MSB:0]         out,
  output logic [CW-1:0]        out_ch,
  output logic                 data_en_out
);

  logic [MSB:0]    gain_q [NCH];
  logic [CW-1:0]   grant_idx;
  s1_slot_t        s1_q;
  s1_slot_t        s1_d;
  logic [MSB:0]    out_q;
  logic [MSB:0]    out_d;
  logic [CW-1:0]   out_ch_q;
  logic            data_en_q;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .advance   (~param_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Gain register file; a write lands before any later issue reads it
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NCH; k++) gain_q[k] <= '0;
    end else if (param_en) begin
      gain_q[param_ch] <= param_in;
    end
  end

  // Capture the winner's sample and gain together so later writes cannot disturb it
  always_comb begin
    s1_d       = '0;
    s1_d.valid = |grant;
    s1_d.ch    = grant_idx;
    s1_d.gain  = gain_q[grant_idx];
    s1_d.data  = data_in[grant_idx*(MSB+1) +: (MSB+1)];
    out_d      = s1_q.gain * s1_q.data;
  end

  // Two-stage pipeline; result registers hold when no new sample arrives
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q      <= '0;
      out_q     <= '0;
      out_ch_q  <= '0;
      data_en_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      data_en_q <= s1_q.valid;
      if (s1_q.valid) begin
        out_q    <= out_d;
        out_ch_q <= s1_q.ch;
      end
    end
  end

  assign out         = out_q;
  assign out_ch      = out_ch_q;
  assign data_en_out = data_en_q;

endmodule

// File: tb/tb_gain_channel_scheduler.sv
// tb/tb_gain_channel_scheduler.sv - directed self-checking bench for gain_channel_scheduler
module tb_gain_channel_scheduler;

  logic         clk;
  logic         rst;
  logic         param_en;
  logic [1:0]   param_ch;
  logic [31:0]  param_in;
  logic [3:0]   req;
  logic [127:0] data_in;
  logic [3:0]   grant;
  logic [31:0]  out;
  logic [1:0]   out_ch;
  logic         data_en_out;

  logic [31:0]  dat [4];
  logic [31:0]  exp_out [4];
  int           errors;
  int           checks;

  assign data_in = {dat[3], dat[2], dat[1], dat[0]};

  gain_channel_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .param_en    (param_en),
    .param_ch    (param_ch),
    .param_in    (param_in),
    .req         (req),
    .data_in     (data_in),
    .grant       (grant),
    .out         (out),
    .out_ch      (out_ch),
    .data_en_out (data_en_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [31:0] val);
    param_en = 1'b1;
    param_ch = ch;
    param_in = val;
    @(negedge clk);
    chk("param_blocks_grant", grant, 0);
    step();
    param_en = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    param_en = 1'b0;
    param_ch = '0;
    param_in = '0;
    req = 4'b1111;
    dat[0] = 1; dat[1] = 2; dat[2] = 3; dat[3] = 4;
    exp_out[0] = 2; exp_out[1] = 6; exp_out[2] = 12; exp_out[3] = 20;

    // reset / idle
    repeat (3) step();
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_out", out, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_den", data_en_out, 0);
    step();
    rst = 1'b1;
    wr(0, 2); wr(1, 3); wr(2, 4); wr(3, 5);

    // all channels requesting: grants 0,1,2,3,0,1 and products two cycles later
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rr_grant", grant, 32'(4'b0001 << (c % 4)));
      if (c >= 2) begin
        chk("stream_den", data_en_out, 1);
        chk("stream_out", out, exp_out[c-2]);
        chk("stream_ch", out_ch, c - 2);
      end else begin
        chk("stream_den_lat", data_en_out, 0);
      end
      step();
    end
    req = 4'b0000;
    @(negedge clk);
    chk("tail0_out", out, 2);
    chk("tail0_ch", out_ch, 0);
    step();
    @(negedge clk);
    chk("tail1_out", out, 6);
    chk("tail1_ch", out_ch, 1);
    step();
    @(negedge clk);
    chk("idle_den", data_en_out, 0);
    chk("hold_out", out, 6);
    chk("hold_ch", out_ch, 1);
    step();

    // round-robin wrap: last winner was 1, so 3 then 0 alternate
    req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wrap_grant", grant, (i % 2 == 0) ? 32'h8 : 32'h1);
      step();
    end
    req = 4'b1011;
    @(negedge clk);
    chk("after0_grant1", grant, 4'b0010);
    step();
    req = 4'b1001;
    @(negedge clk);
    chk("after1_grant3", grant, 4'b1000);
    step();
    req = 4'b0000;
    step();
    step();

    // parameter priority and gain hazard on channel 2
    dat[2] = 10;
    req = 4'b0100;
    wr(2, 7);
    @(negedge clk);
    chk("hz_issue_old", grant, 4'b0100);
    step();
    param_en = 1'b1;
    param_ch = 2;
    param_in = 9;
    @(negedge clk);
    chk("hz_write_blocks", grant, 0);
    step();
    param_en = 1'b0;
    @(negedge clk);
    chk("hz_issue_new", grant, 4'b0100);
    chk("hz_old_den", data_en_out, 1);
    chk("hz_old_out", out, 70);
    chk("hz_old_ch", out_ch, 2);
    step();
    req = 4'b0000;
    @(negedge clk);
    chk("hz_slot_lost", data_en_out, 0);
    step();
    @(negedge clk);
    chk("hz_new_den", data_en_out, 1);
    chk("hz_new_out", out, 90);
    step();
    step();

    // truncation of the product to 32 bits
    dat[0] = 32'h0003_0000;
    dat[1] = 32'd2;
    wr(0, 32'h0001_0000);
    wr(1, 32'hFFFF_FFFF);
    req = 4'b0011;
    @(negedge clk);
    chk("tr_grant0", grant, 4'b0001);
    step();
    req = 4'b0010;
    @(negedge clk);
    chk("tr_grant1", grant, 4'b0010);
    step();
    req = 4'b0000;
    @(negedge clk);
    chk("tr0_den", data_en_out, 1);
    chk("tr0_out", out, 32'h0000_0000);
    step();
    @(negedge clk);
    chk("tr1_out", out, 32'hFFFF_FFFE);
    chk("tr1_ch", out_ch, 1);
    step();

    // mid-stream reset
    dat[0] = 1; dat[1] = 2; dat[2] = 3; dat[3] = 4;
    req = 4'b1111;
    @(negedge clk);
    chk("mr_grant2", grant, 4'b0100);
    step();
    @(negedge clk);
    chk("mr_grant3", grant, 4'b1000);
    step();
    @(negedge clk);
    chk("mr_pre_out", out, 27);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_rst_grant", grant, 0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("mr_den0", data_en_out, 0);
    chk("mr_out_cleared", out, 0);
    chk("mr_first_grant", grant, 4'b0001);
    step();
    @(negedge clk);
    chk("mr_den1", data_en_out, 0);
    chk("mr_second_grant", grant, 4'b0010);
    step();
    req = 4'b0000;
    @(negedge clk);
    chk("mr_reissue_den", data_en_out, 1);
    chk("mr_gain0_zero", out, 0);
    chk("mr_reissue_ch", out_ch, 0);
    step();
    @(negedge clk);
    chk("mr_gain1_zero", out, 0);
    chk("mr_reissue_ch1", out_ch, 1);
    step();

    // request withdrawn during a parameter write
    param_en = 1'b1;
    param_ch = 3;
    param_in = 6;
    req = 4'b0010;
    @(negedge clk);
    chk("wd_blocked", grant, 0);
    step();
    param_en = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    chk("wd_no_grant", grant, 0);
    step();
    @(negedge clk);
    chk("wd_no_out0", data_en_out, 0);
    step();
    @(negedge clk);
    chk("wd_no_out1", data_en_out, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
